dramsync_reset_seq: RTL and testbench



---
 rtl/dramsync_reset_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_dramsync_reset_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dramsync_reset_seq.sv
// -----------------------------------------------------------------------------
// dramsync_reset_seq
//
// Clock-start and reset sequencer for the DRAM clocking tree. It runs on the
// 100 MHz reference clock. It waits for a filtered PLL lock, then holds the
// DRAM domain in power-on reset for POR_CYCLES. Next it releases the clock
// divider reset, and after that starts the edge clock. This order makes
// sync2x (200 MHz) and dramsync (100 MHz) start phase-aligned. Only after
// these steps does it release dramsync_rst to the PHY and controller.
//
// Parameters:
//   LOCK_FILTER  consecutive high pll_locked samples needed before the
//                sequence proceeds (>= 1)
//   POR_CYCLES   power-on reset dwell in clk cycles (>= 1)
//   STEP_CYCLES  dwell of each clock-start step in clk cycles (>= 1)
//
// Ports:
//   clk           in   100 MHz reference clock
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock, already synchronised to clk
//   restart       in   one-cycle request to rerun the whole sequence
//   eclk_stop     out  edge-clock sync stop (1 = stopped)
//   clkdiv_rst    out  clock divider reset (1 = in reset)
//   dramsync_rst  out  DRAM domain reset (1 = in reset)
//   ready         out  high while the sequence is in RUN
//   restarts      out  saturating count of aborted/restarted sequences
//
// Configuration macro:
//   DRAMSYNC_RESET_SEQ_LOCK_MON_EN
//     Defined:   loss of PLL lock while in RUN aborts back to WAIT_LOCK.
//     Undefined: pll_locked is ignored in RUN, so only restart leaves RUN.
//   The production build is expected to define this macro.
//   Lock loss always aborts the earlier sequence states, in either build.
// -----------------------------------------------------------------------------
module dramsync_reset_seq #(
    parameter int LOCK_FILTER = 16,
    parameter int POR_CYCLES  = 60000,
    parameter int STEP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       eclk_stop,
    output logic       clkdiv_rst,
    output logic       dramsync_rst,
    output logic       ready,
    output logic [7:0] restarts
);

    // One counter width serves both the lock filter and the dwell counter.
    // It is sized for the largest parameter, so a load value always fits.
    localparam int MAX_AB    = (LOCK_FILTER > POR_CYCLES) ? LOCK_FILTER : POR_CYCLES;
    localparam int MAX_PARAM = (MAX_AB > STEP_CYCLES) ? MAX_AB : STEP_CYCLES;
    localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

    // The dwell counter is loaded with N-1. The state then advances on the
    // edge that samples zero, which gives a dwell of exactly N cycles.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_POR_WAIT    = 3'd1,
        ST_RELEASE_DIV = 3'd2,
        ST_START_ECLK  = 3'd3,
        ST_RUN         = 3'd4
    } state_e;

    state_e           state_q,        state_d;
    logic [CNT_W-1:0] lock_cnt_q,     lock_cnt_d;
    logic [CNT_W-1:0] dwell_cnt_q,    dwell_cnt_d;
    logic [7:0]       restarts_q,     restarts_d;
    logic             eclk_stop_q,    eclk_stop_d;
    logic             clkdiv_rst_q,   clkdiv_rst_d;
    logic             dramsync_rst_q, dramsync_rst_d;
    logic             ready_q,        ready_d;

    logic             lock_abort_en;
    logic             abort;

    // lock_abort_en is true in the states where loss of lock counts as an
    // abort. RUN is included only when lock monitoring is built in.
`ifdef DRAMSYNC_RESET_SEQ_LOCK_MON_EN
    assign lock_abort_en = 1'b1;
`else
    assign lock_abort_en = (state_q != ST_RUN);
`endif

    // Any abort source is one event. If restart and lock loss arrive in the
    // same cycle, the restart counter still increments only once.
    assign abort = (state_q != ST_WAIT_LOCK) &&
                   (restart || (!pll_locked && lock_abort_en));

    // Next-state and counter logic.
    // The outputs are decoded from the next state. Because they are
    // registered, they change on the same edge as the state register.
    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        restarts_d  = restarts_q;

        if (abort) begin
            state_d     = ST_WAIT_LOCK;
            lock_cnt_d  = CNT_ZERO;
            dwell_cnt_d = CNT_ZERO;
            if (restarts_q != 8'hFF) begin
                restarts_d = restarts_q + 8'd1;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    // A restart in this state only clears the lock filter.
                    // It does not count as a restart.
                    if (restart || !pll_locked) begin
                        lock_cnt_d = CNT_ZERO;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d     = ST_POR_WAIT;
                        lock_cnt_d  = CNT_ZERO;
                        dwell_cnt_d = POR_LOAD;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CNT_ONE;
                    end
                end

                ST_POR_WAIT: begin
                    if (dwell_cnt_q == CNT_ZERO) begin
                        state_d     = ST_RELEASE_DIV;
                        dwell_cnt_d = STEP_LOAD;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - CNT_ONE;
                    end
                end

                ST_RELEASE_DIV: begin
                    if (dwell_cnt_q == CNT_ZERO) begin
                        state_d     = ST_START_ECLK;
                        dwell_cnt_d = STEP_LOAD;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - CNT_ONE;
                    end
                end

                ST_START_ECLK: begin
                    if (dwell_cnt_q == CNT_ZERO) begin
                        state_d     = ST_RUN;
                        dwell_cnt_d = CNT_ZERO;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - CNT_ONE;
                    end
                end

                ST_RUN: begin
                    state_d = ST_RUN;
                end

                default: begin
                    state_d     = ST_WAIT_LOCK;
                    lock_cnt_d  = CNT_ZERO;
                    dwell_cnt_d = CNT_ZERO;
                end
            endcase
        end

        // The states are ordered so that the divider leaves reset while the
        // edge clock is still stopped. The DRAM reset is released only after
        // both clocks are running.
        eclk_stop_d    = 1'b1;
        clkdiv_rst_d   = 1'b1;
        dramsync_rst_d = 1'b1;
        ready_d        = 1'b0;
        case (state_d)
            ST_RELEASE_DIV: begin
                clkdiv_rst_d = 1'b0;
            end
            ST_START_ECLK: begin
                eclk_stop_d  = 1'b0;
                clkdiv_rst_d = 1'b0;
            end
            ST_RUN: begin
                eclk_stop_d    = 1'b0;
                clkdiv_rst_d   = 1'b0;
                dramsync_rst_d = 1'b0;
                ready_d        = 1'b1;
            end
            default: begin
                eclk_stop_d    = 1'b1;
                clkdiv_rst_d   = 1'b1;
                dramsync_rst_d = 1'b1;
                ready_d        = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. An asynchronous reset forces
    // every output to its safe value at once, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_WAIT_LOCK;
            lock_cnt_q     <= CNT_ZERO;
            dwell_cnt_q    <= CNT_ZERO;
            restarts_q     <= 8'd0;
            eclk_stop_q    <= 1'b1;
            clkdiv_rst_q   <= 1'b1;
            dramsync_rst_q <= 1'b1;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
            restarts_q     <= restarts_d;
            eclk_stop_q    <= eclk_stop_d;
            clkdiv_rst_q   <= clkdiv_rst_d;
            dramsync_rst_q <= dramsync_rst_d;
            ready_q        <= ready_d;
        end
    end

    assign eclk_stop    = eclk_stop_q;
    assign clkdiv_rst   = clkdiv_rst_q;
    assign dramsync_rst = dramsync_rst_q;
    assign ready        = ready_q;
    assign restarts     = restarts_q;

endmodule

// File: tb/tb_dramsync_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_dramsync_reset_seq
//
// Self-checking bench for dramsync_reset_seq.
// It runs with LOCK_FILTER=4, POR_CYCLES=100 and STEP_CYCLES=3.
// A behavioural model tracks where the sequence is, as the number of edges
// since lock was accepted. The expected outputs are derived from the dwell
// times. The bench compares every output against the model after each clock.
// It also makes explicit checks at the edges of the directed scenarios.
// Expectations for lock loss in RUN follow DRAMSYNC_RESET_SEQ_LOCK_MON_EN.
// -----------------------------------------------------------------------------
module tb_dramsync_reset_seq;

    localparam int LF   = 4;
    localparam int POR  = 100;
    localparam int STEP = 3;
    localparam int RUN_T = POR + 2 * STEP;

`ifdef DRAMSYNC_RESET_SEQ_LOCK_MON_EN
    localparam bit LOCK_MON = 1'b1;
`else
    localparam bit LOCK_MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       eclk_stop;
    logic       clkdiv_rst;
    logic       dramsync_rst;
    logic       ready;
    logic [7:0] restarts;

    int n_checks = 0;
    int n_fails  = 0;
    int edge_no  = 0;

    // Model state: whether a sequence is active, and how many edges have
    // passed since the lock filter was satisfied.
    int  m_high     = 0;
    bit  m_active   = 1'b0;
    int  m_t        = 0;
    int  m_restarts = 0;
    bit  m_abort;

    dramsync_reset_seq #(
        .LOCK_FILTER (LF),
        .POR_CYCLES  (POR),
        .STEP_CYCLES (STEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .eclk_stop    (eclk_stop),
        .clkdiv_rst   (clkdiv_rst),
        .dramsync_rst (dramsync_rst),
        .ready        (ready),
        .restarts     (restarts)
    );

    // Free-running 100 MHz reference clock.
    always #5 clk = ~clk;

    // Reference model, advanced on the same edge as the DUT. Inputs change
    // only on the falling edge, so the model sees the same samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_high     = 0;
            m_active   = 1'b0;
            m_t        = 0;
            m_restarts = 0;
        end else if (!m_active) begin
            if (restart || !pll_locked) m_high = 0;
            else m_high = m_high + 1;
            if (m_high == LF) begin
                m_active = 1'b1;
                m_t      = 0;
                m_high   = 0;
            end
        end else begin
            m_abort = restart || (!pll_locked && ((m_t < RUN_T) || LOCK_MON));
            if (m_abort) begin
                m_active = 1'b0;
                m_high   = 0;
                if (m_restarts < 255) m_restarts = m_restarts + 1;
            end else if (m_t < 1000000) begin
                m_t = m_t + 1;
            end
        end
    end

    // Expected {eclk_stop, clkdiv_rst, dramsync_rst, ready}, found from how
    // far the sequence has progressed through its dwell times.
    function automatic logic [3:0] expOutputs();
        if (!m_active || m_t < POR)  return 4'b1110;
        if (m_t < POR + STEP)        return 4'b1010;
        if (m_t < RUN_T)             return 4'b0010;
        return 4'b0001;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (edge %0d, t=%0t)",
                     tag, observed, expected, edge_no, $time);
        end
    endtask

    task automatic compareModel();
        logic [3:0] e;
        e = expOutputs();
        checkOutput("model_eclk_stop",    int'(eclk_stop),    int'(e[3]));
        checkOutput("model_clkdiv_rst",   int'(clkdiv_rst),   int'(e[2]));
        checkOutput("model_dramsync_rst", int'(dramsync_rst), int'(e[1]));
        checkOutput("model_ready",        int'(ready),        int'(e[0]));
        checkOutput("model_restarts",     int'(restarts),     m_restarts);
    endtask

    // Drive one cycle of inputs, let one rising edge take them, then compare
    // against the model on the falling edge.
    task automatic applyStimulus(input bit lock, input bit rs);
        pll_locked = lock;
        restart    = rs;
        @(posedge clk);
        @(negedge clk);
        edge_no++;
        compareModel();
        restart = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_eclk_stop"},    int'(eclk_stop),    1);
        checkOutput({tag, "_clkdiv_rst"},   int'(clkdiv_rst),   1);
        checkOutput({tag, "_dramsync_rst"}, int'(dramsync_rst), 1);
        checkOutput({tag, "_ready"},        int'(ready),        0);
        checkOutput({tag, "_restarts"},     int'(restarts),     0);
    endtask

    // Ordering invariants, checked on every cycle of every scenario:
    // the divider leaves reset only while the edge clock is stopped, and the
    // DRAM reset is released only with both clocks running.
    logic prev_div  = 1'b1;
    logic prev_dram = 1'b1;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_div && !clkdiv_rst)
                checkOutput("inv_div_fall_with_eclk_stopped", int'(eclk_stop), 1);
            if (prev_dram && !dramsync_rst)
                checkOutput("inv_dram_fall_with_clocks_up", int'({eclk_stop, clkdiv_rst}), 0);
        end
        prev_div  = clkdiv_rst;
        prev_dram = dramsync_rst;
    end

    initial begin
        // Reset state.
        pll_locked = 1'b1;
        @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        // Nominal start: lock is high from the first edge.
        edge_no = 0;
        for (int i = 0; i < 110; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (edge_no == 103) checkOutput("nom_div_still_rst_103", int'(clkdiv_rst), 1);
            if (edge_no == 104) checkOutput("nom_div_fall_104", int'(clkdiv_rst), 0);
            if (edge_no == 106) checkOutput("nom_eclk_still_stop_106", int'(eclk_stop), 1);
            if (edge_no == 107) checkOutput("nom_eclk_fall_107", int'(eclk_stop), 0);
            if (edge_no == 109) checkOutput("nom_not_ready_109", int'(ready), 0);
            if (edge_no == 110) begin
                checkOutput("nom_ready_110", int'(ready), 1);
                checkOutput("nom_dram_rel_110", int'(dramsync_rst), 0);
                checkOutput("nom_restarts", int'(restarts), 0);
            end
        end

        // A restart pulse in RUN returns to WAIT_LOCK on the next edge.
        applyStimulus(1'b1, 1'b1);
        checkOutput("run_restart_ready", int'(ready), 0);
        checkOutput("run_restart_dram", int'(dramsync_rst), 1);
        checkOutput("run_restart_eclk", int'(eclk_stop), 1);
        checkOutput("run_restart_count", int'(restarts), 1);

        // Lock glitch 1,1,1,0,1,1,1,1: POR_WAIT is entered at edge 8, so the
        // divider is released at edge 108.
        begin
            bit glitch [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            edge_no = 0;
            for (int i = 0; i < 8; i++) applyStimulus(glitch[i], 1'b0);
            for (int i = 8; i < 108; i++) begin
                applyStimulus(1'b1, 1'b0);
                if (edge_no == 107) checkOutput("glitch_div_rst_107", int'(clkdiv_rst), 1);
                if (edge_no == 108) checkOutput("glitch_div_fall_108", int'(clkdiv_rst), 0);
            end
            checkOutput("glitch_restarts", int'(restarts), 1);
        end
        // Lock loss in RELEASE_DIV aborts.
        applyStimulus(1'b0, 1'b0);
        checkOutput("reldiv_loss_div", int'(clkdiv_rst), 1);
        checkOutput("reldiv_loss_count", int'(restarts), 2);

        // Lock loss in POR_WAIT at edge 50, followed by a full relock.
        edge_no = 0;
        for (int i = 1; i < 50; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("por_loss_dram", int'(dramsync_rst), 1);
        checkOutput("por_loss_div", int'(clkdiv_rst), 1);
        checkOutput("por_loss_count", int'(restarts), 3);
        edge_no = 0;
        for (int i = 0; i < 110; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (edge_no == 109) checkOutput("relock_not_ready_109", int'(ready), 0);
            if (edge_no == 110) checkOutput("relock_ready_110", int'(ready), 1);
        end

        // Lock drop in RUN: aborts only when lock monitoring is built in.
        applyStimulus(1'b0, 1'b0);
        checkOutput("run_lockdrop_ready", int'(ready), LOCK_MON ? 0 : 1);
        checkOutput("run_lockdrop_dram", int'(dramsync_rst), LOCK_MON ? 1 : 0);
        checkOutput("run_lockdrop_count", int'(restarts), LOCK_MON ? 4 : 3);
        // A restart now leaves RUN (monitor off) or is only a filter clear in
        // WAIT_LOCK (monitor on). In both builds the count ends at 4.
        applyStimulus(1'b0, 1'b1);
        checkOutput("after_drop_restart_ready", int'(ready), 0);
        checkOutput("after_drop_restart_count", int'(restarts), 4);

        // Restart and lock drop in the same cycle count as a single restart.
        for (int i = 0; i < LF + 2; i++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("simul_abort_count", int'(restarts), 5);

        // Async reset in the middle of START_ECLK, between two edges.
        edge_no = 0;
        for (int i = 0; i < 108; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_async_eclk_running", int'(eclk_stop), 0);
        checkOutput("pre_async_dram_rst", int'(dramsync_rst), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 300 restarts, each taken from POR_WAIT.
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < LF; i++) applyStimulus(1'b1, 1'b0);
            applyStimulus(1'b1, 1'b1);
            if (r == 254) checkOutput("sat_reach_255", int'(restarts), 255);
        end
        checkOutput("sat_hold_255", int'(restarts), 255);

        // Randomised run: rare lock drops and restarts, compared each cycle.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 399) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
